// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helper for the InvMixColumns datapath.
package aes_pkg;

  localparam int unsigned STATE_W  = 128;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NUM_COLS = 4;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [BYTE_W-1:0] GF_RED = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // Multiply by x (02) in GF(2^8).
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_RED : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mc_column.sv
// Combinational InvMixColumns for one 32-bit column, built from four inverse row multipliers.

// One output byte: 0e*a ^ 0b*b ^ 0d*c ^ 09*d.
module inv_mc_row
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic [BYTE_W-1:0] c,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] y
);

  logic [BYTE_W-1:0] a2, a4, a8;
  logic [BYTE_W-1:0] b2, b4, b8;
  logic [BYTE_W-1:0] c2, c4, c8;
  logic [BYTE_W-1:0] d2, d4, d8;

  // Powers of x for each input byte, then combine into the fixed coefficients.
  always_comb begin
    a2 = xtime(a);  a4 = xtime(a2);  a8 = xtime(a4);
    b2 = xtime(b);  b4 = xtime(b2);  b8 = xtime(b4);
    c2 = xtime(c);  c4 = xtime(c2);  c8 = xtime(c4);
    d2 = xtime(d);  d4 = xtime(d2);  d8 = xtime(d4);
    y  = (a8 ^ a4 ^ a2)     // 0e * a
       ^ (b8 ^ b2 ^ b)      // 0b * b
       ^ (c8 ^ c4 ^ c)      // 0d * c
       ^ (d8 ^ d);          // 09 * d
  end

endmodule

module inv_mc_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] s0, s1, s2, s3;

  assign s0 = col_in[7:0];
  assign s1 = col_in[15:8];
  assign s2 = col_in[23:16];
  assign s3 = col_in[31:24];

  // Each row is the same multiplier with the input bytes rotated.
  inv_mc_row u_row0 (.a(s0), .b(s1), .c(s2), .d(s3), .y(col_out[7:0]));
  inv_mc_row u_row1 (.a(s1), .b(s2), .c(s3), .d(s0), .y(col_out[15:8]));
  inv_mc_row u_row2 (.a(s2), .b(s3), .c(s0), .d(s1), .y(col_out[23:16]));
  inv_mc_row u_row3 (.a(s3), .b(s0), .c(s1), .d(s2), .y(col_out[31:24]));

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: one shared column multiplier, one column per cycle,
// valid/ready on both sides. Optional final-round bypass under INV_MC_BYPASS_EN.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
`ifdef INV_MC_BYPASS_EN
  ,
  input  logic               bypass
`endif
);

  mc_state_t          state;
  logic [1:0]         col;
  logic [STATE_W-1:0] work;
  logic [COL_W-1:0]   col_in_c;
  logic [COL_W-1:0]   col_out_c;
  logic               take_bypass_c;

`ifdef INV_MC_BYPASS_EN
  assign take_bypass_c = bypass;
`else
  assign take_bypass_c = 1'b0;
`endif

  // Select the column currently being transformed.
  assign col_in_c = work[{col, 5'b0} +: COL_W];

  inv_mc_column u_col (
    .col_in  (col_in_c),
    .col_out (col_out_c)
  );

  assign out_data = work;

  // Control FSM plus in-place working register; handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= 2'd0;
      work      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            col      <= 2'd0;
            in_ready <= 1'b0;
            if (take_bypass_c) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          work[{col, 5'b0} +: COL_W] <= col_out_c;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Column-serial AES InvMixColumns stage for the decryption datapath. Accepts a 128-bit state after inverse AddRoundKey and applies InvMixColumns one 32-bit column per cycle through a single shared column multiplier built from the inverse row-multiply blocks. Presents the result to the next inverse round stage over a valid/ready handshake. Trades four cycles of latency for one quarter of the GF(2^8) multiplier area.

## Interface
- No parameters; widths are fixed by AES (state 128, column 32, byte 8).
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a state
- in_data  input  128  state; column c = in_data[32c+31:32c], byte r of column = bits [8r+7:8r]
- out_valid  output  1  out_data holds a finished state
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  result, same byte/column layout as in_data
- bypass  input  1  present only with INV_MC_BYPASS_EN; sampled with in_data

## Operation
- Per column (s0..s3 = bytes 0..3), all products in GF(2^8), poly 0x11B, sum = XOR:
  - r0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - r1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - r2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - r3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
- Internal 128-bit working register; results are written in place over the consumed column.
- 2-bit column counter col, 0..3, wraps to 0 only via the FSM.
- FSM states:
  - IDLE: in_ready=1. On in_valid: load register, col=0, go to BUSY.
  - BUSY: each cycle, column col is replaced by its result and col increments. After col=3 is written, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is high only in IDLE. in_valid outside IDLE is ignored and nothing is sampled.
- out_data is held stable throughout DONE, regardless of in_valid.

## Timing
- Reset values: FSM=IDLE, col=0, working register=0, out_valid=0, in_ready=1 (first cycle after reset), out_data=128'h0.
- Acceptance at the edge ending cycle T. Columns 0..3 are written at the edges ending T+1..T+4. out_valid is high from cycle T+5.
- Latency is 5 cycles from acceptance to out_valid. With out_ready held high, throughput is 1 state per 6 cycles: out handshake in T+5, IDLE in T+6.
- Handshake completes on the edge where out_valid && out_ready. out_valid is low the next cycle.
- Reset mid-operation (BUSY or DONE): the next cycle is IDLE and the partial or unread state is discarded. rst overrides all simultaneous handshakes.
- out_ready while not in DONE has no effect.

## Configuration
- INV_MC_BYPASS_EN defined:
  - Adds the bypass port, which serves the final decryption round with no InvMixColumns.
  - bypass=1 at acceptance: the register loads in_data unchanged and the FSM goes IDLE→DONE directly. out_valid is high in T+1 and out_data equals in_data.
  - bypass=0: normal operation.
- INV_MC_BYPASS_EN undefined: there is no bypass port and every state takes the 4-column path.

## Structure
- Shared package aes_pkg holds:
  - state/column/byte width constants
  - FSM state enum (IDLE, BUSY, DONE)
  - GF reduction constant 8'h1B
- One sub-module, inv_mc_column (32-bit in → 32-bit out, combinational). It instantiates the four inverse row multipliers with correct byte slices [7:0], [15:8], [23:16], [31:24]. It is instantiated once and muxed by col.

## Test plan
- Single column vector: every column = 32'hbca14d8e (bytes 8e 4d a1 bc) -> every output column 32'h455313db (db 13 53 45); out_valid exactly 5 cycles after acceptance.
- Mixed state: columns 0..3 = 32'h9d58dc9f, 32'hbca14d8e, 32'hc6c6c6c6, 32'h01010101 -> 32'h5c220af2, 32'h455313db, 32'hc6c6c6c6, 32'h01010101.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling in_valid with new data -> out_data unchanged, in_ready=0 throughout, new data never absorbed; accepted only after IDLE.
- Back-to-back stream of 3 states with out_ready=1 -> each result correct and ordered, 6-cycle spacing.
- Reset at T+2 (mid-BUSY) -> next cycle IDLE, out_valid=0, out_data=0; the following state is processed correctly.
- With INV_MC_BYPASS_EN, bypass=1, in_data=128'h00112233445566778899aabbccddeeff -> out_valid in T+1 with identical data; a bypass=0 state following it takes 5 cycles.
